ms_uart_fifo_lvl: RTL and testbench

Parametrised, level-aware UART FIFO that replaces the fixed single-mode FIFO in the TX and RX paths of the AHB UART. It adds an occupancy count, a programmable fill-threshold flag, sticky overrun/underrun error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) output mode. One instance sits between the AHB register slave and each UART shifter.

---
 rtl/ms_uart_pkg.sv | 20 ++
 rtl/ms_uart_fifo_mem.sv | 33 +++
 rtl/ms_uart_fifo_lvl.sv | 115 +++++++++++
 tb/tb_ms_uart_fifo_lvl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ms_uart_pkg.sv
//==============================================================================
// Module      : ms_uart_pkg
// Description : Shared constants and helpers for the AHB UART FIFO blocks.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package ms_uart_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Pointer width: address bits plus one wrap bit
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ms_uart_fifo_mem.sv
//==============================================================================
// Module      : ms_uart_fifo_mem
// Description : DEPTH x DWIDTH register array, one write port, async read port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ms_uart_fifo_mem #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/ms_uart_fifo_lvl.sv
//==============================================================================
// Module      : ms_uart_fifo_lvl
// Description : Level-aware UART FIFO with count, threshold, error flags, flush
//               and selectable registered / first-word-fall-through output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ms_uart_fifo_lvl
    import ms_uart_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 16,
    parameter int FWFT   = 0,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              FLUSH,
    input  logic              WR,
    input  logic [DWIDTH-1:0] DIN,
    input  logic              RD,
    output logic [DWIDTH-1:0] DOUT,
    output logic              EMPTY,
    output logic              FULL,
    output logic [AW:0]       COUNT,
    input  logic [AW:0]       THRESH,
    output logic              THRESH_HIT,
    output logic              OVERRUN,
    output logic              UNDERRUN,
    input  logic              CLR_ERR
);

    localparam int PW = ptr_width(DEPTH);

    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic              r_overrun;
    logic              r_underrun;
    logic              w_empty;
    logic              w_full;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DWIDTH-1:0] w_rdata;

    // Full when the pointers differ only in the wrap bit
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = ((r_wptr ^ r_rptr) == {1'b1, {AW{1'b0}}});
    assign w_wr_acc = WR && !w_full  && !FLUSH;
    assign w_rd_acc = RD && !w_empty && !FLUSH;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (FLUSH) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
            if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
        end
    end

    // A new error event wins over a same-cycle clear
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (WR && w_full && !FLUSH) r_overrun <= 1'b1;
            else if (CLR_ERR)           r_overrun <= 1'b0;
            if (RD && w_empty && !FLUSH) r_underrun <= 1'b1;
            else if (CLR_ERR)            r_underrun <= 1'b0;
        end
    end

    ms_uart_fifo_mem #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_mem (
        .CLK     (CLK),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr[AW-1:0]),
        .i_wdata (DIN),
        .i_raddr (r_rptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign DOUT = w_rdata;
        end else begin : g_reg
            logic [DWIDTH-1:0] r_dout;
            always_ff @(posedge CLK or negedge RESETN) begin
                if (!RESETN) begin
                    r_dout <= '0;
                end else if (w_rd_acc) begin
                    r_dout <= w_rdata;
                end
            end
            assign DOUT = r_dout;
        end
    endgenerate

    assign EMPTY      = w_empty;
    assign FULL       = w_full;
    assign COUNT      = r_wptr - r_rptr;
    assign THRESH_HIT = (THRESH != '0) && (COUNT >= THRESH);
    assign OVERRUN    = r_overrun;
    assign UNDERRUN   = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_ms_uart_fifo_lvl.sv
//==============================================================================
// Module      : tb_ms_uart_fifo_lvl
// Description : Directed self-checking bench, registered and FWFT instances
//               driven in lockstep against a queue model and scoreboard.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ms_uart_fifo_lvl;

    localparam int DW = 8;
    localparam int DP = 4;

    logic          CLK = 1'b0;
    logic          RESETN = 1'b0;
    logic          FLUSH = 1'b0;
    logic          WR = 1'b0;
    logic [DW-1:0] DIN = '0;
    logic          RD = 1'b0;
    logic [2:0]    THRESH = '0;
    logic          CLR_ERR = 1'b0;

    logic [DW-1:0] dout_r, dout_f;
    logic          empty_r, full_r, th_r, ovr_r, udr_r;
    logic          empty_f, full_f, th_f, ovr_f, udr_f;
    logic [2:0]    count_r, count_f;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] q_model [$];
    logic [DW-1:0] q_sb    [$];
    logic [DW-1:0] m_dout;
    logic          m_ovr, m_udr;

    always #5 CLK = ~CLK;

    ms_uart_fifo_lvl #(.DWIDTH(DW), .DEPTH(DP), .FWFT(0)) dut_r (
        .CLK(CLK), .RESETN(RESETN), .FLUSH(FLUSH), .WR(WR), .DIN(DIN), .RD(RD),
        .DOUT(dout_r), .EMPTY(empty_r), .FULL(full_r), .COUNT(count_r),
        .THRESH(THRESH), .THRESH_HIT(th_r), .OVERRUN(ovr_r), .UNDERRUN(udr_r),
        .CLR_ERR(CLR_ERR)
    );

    ms_uart_fifo_lvl #(.DWIDTH(DW), .DEPTH(DP), .FWFT(1)) dut_f (
        .CLK(CLK), .RESETN(RESETN), .FLUSH(FLUSH), .WR(WR), .DIN(DIN), .RD(RD),
        .DOUT(dout_f), .EMPTY(empty_f), .FULL(full_f), .COUNT(count_f),
        .THRESH(THRESH), .THRESH_HIT(th_f), .OVERRUN(ovr_f), .UNDERRUN(udr_f),
        .CLR_ERR(CLR_ERR)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        int  n;
        logic th_exp;
        n = q_model.size();
        th_exp = (THRESH != 0) && (n >= int'(THRESH));
        chk("count",    32'(count_r), 32'(n));
        chk("empty",    32'(empty_r), 32'(n == 0));
        chk("full",     32'(full_r),  32'(n == DP));
        chk("overrun",  32'(ovr_r),   32'(m_ovr));
        chk("underrun", 32'(udr_r),   32'(m_udr));
        chk("thresh",   32'(th_r),    32'(th_exp));
        chk("f_count",  32'(count_f), 32'(n));
        chk("f_empty",  32'(empty_f), 32'(n == 0));
        if (n > 0) chk("f_dout", 32'(dout_f), 32'(q_model[0]));
    endtask

    // One clock of stimulus; model the accept decisions from pre-edge state
    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd,
                        input logic fl = 1'b0, input logic clr = 1'b0);
        logic is_full, is_empty, rd_acc;
        @(negedge CLK);
        WR = wr; DIN = d; RD = rd; FLUSH = fl; CLR_ERR = clr;
        is_full  = (q_model.size() == DP);
        is_empty = (q_model.size() == 0);
        rd_acc   = 1'b0;
        if (fl) begin
            q_model.delete();
        end else begin
            if (rd && !is_empty) begin
                rd_acc = 1'b1;
                q_sb.push_back(q_model.pop_front());
            end
            if (wr && !is_full) q_model.push_back(d);
        end
        if (wr && is_full && !fl)       m_ovr = 1'b1;
        else if (clr)                   m_ovr = 1'b0;
        if (rd && is_empty && !fl)      m_udr = 1'b1;
        else if (clr)                   m_udr = 1'b0;
        @(posedge CLK);
        #1;
        WR = 1'b0; RD = 1'b0; FLUSH = 1'b0; CLR_ERR = 1'b0;
        if (rd_acc) begin
            m_dout = q_sb.pop_front();
            chk("dout_read", 32'(dout_r), 32'(m_dout));
        end else begin
            chk("dout_hold", 32'(dout_r), 32'(m_dout));
        end
        chk_state();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_count", 32'(count_r), 0);
        chk("rst_empty", 32'(empty_r), 1);
        chk("rst_full",  32'(full_r),  0);
        chk("rst_dout",  32'(dout_r),  0);
        chk("rst_ovr",   32'(ovr_r),   0);
        chk("rst_udr",   32'(udr_r),   0);
        chk("rst_th",    32'(th_r),    0);
        chk("rst_f_cnt", 32'(count_f), 0);
        chk("rst_f_emp", 32'(empty_f), 1);
    endtask

    initial begin
        m_dout = '0; m_ovr = 1'b0; m_udr = 1'b0;
        THRESH = 3'd1;
        #3;
        chk_reset_outputs();
        @(negedge CLK);
        RESETN = 1'b1;
        THRESH = 3'd0;

        // Fill, overrun on the fifth write, then drain in order
        step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0); step(1, 8'h44, 0);
        step(1, 8'h55, 0);
        chk("fill_full", 32'(full_r), 1);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
        chk("drain_last", 32'(dout_r), 32'h44);

        // Underrun and error clear
        step(0, 8'h00, 1);
        chk("udr_set", 32'(udr_r), 1);
        step(0, 8'h00, 0, 0, 1);
        chk("udr_clr", 32'(udr_r), 0);

        // Simultaneous access across pointer wrap
        step(1, 8'hA0, 0); step(1, 8'hA1, 0);
        for (int i = 0; i < 10; i++) step(1, 8'(8'hB0 + i), 1);
        step(1, 8'hC0, 0); step(1, 8'hC1, 0);
        step(1, 8'hC2, 1);
        chk("full_rw_cnt", 32'(count_r), 3);
        chk("full_rw_ovr", 32'(ovr_r), 1);

        // Flush keeps the sticky overrun and holds DOUT
        step(0, 8'h00, 0, 1);
        THRESH = 3'd3;
        step(1, 8'h31, 0); step(1, 8'h32, 0);
        chk("th_below", 32'(th_r), 0);
        step(1, 8'h33, 0);
        chk("th_hit", 32'(th_r), 1);
        step(1, 8'h34, 1, 1);
        chk("flush_ovr", 32'(ovr_r), 1);
        THRESH = 3'd0;
        for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0);
        THRESH = 3'd5;
        step(0, 8'h00, 0);

        // First-word fall-through
        step(0, 8'h00, 0, 1, 1);
        step(1, 8'hA5, 0);
        chk("fwft_head", 32'(dout_f), 32'hA5);
        chk("fwft_nemp", 32'(empty_f), 0);
        step(0, 8'h00, 1);
        chk("fwft_pop", 32'(empty_f), 1);

        // Asynchronous reset with two entries and a pending read
        THRESH = 3'd1;
        step(1, 8'hD1, 0); step(1, 8'hD2, 0);
        @(negedge CLK);
        RD = 1'b1;
        #2;
        RESETN = 1'b0;
        #1;
        chk_reset_outputs();
        @(posedge CLK);
        #1;
        chk("rst_inflight", 32'(dout_r), 0);
        RD = 1'b0;
        @(negedge CLK);
        RESETN = 1'b1;
        q_model.delete(); q_sb.delete();
        m_dout = '0; m_ovr = 1'b0; m_udr = 1'b0;
        step(1, 8'hE1, 0);
        step(0, 8'h00, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
